jump_ctrl: RTL and testbench

- Initiator side of the program-counter jump interface. Decodes the branch field of the instruction currently addressed by programCounter and drives jumpEn/target so the counter loads the target on the next clock edge.
- Holds a writable branch-target lookup table, registered condition flags, and a return-address stack for CALL/RET.
- Sits between the instruction decoder/ALU and the program counter.

---
 rtl/jump_ctrl_pkg.sv | 21 ++
 rtl/jump_ctrl_ret_stack.sv | 53 +++++
 rtl/jump_ctrl.sv | 124 ++++++++++++
 tb/tb_jump_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/jump_ctrl_pkg.sv
// Shared definitions for the program-counter jump initiator.
//   br_op_e : branch opcode field of the current instruction
//   D_DEF   : default program-counter / target width
//   L_DEF   : default branch-target LUT index width
package jump_ctrl_pkg;

   typedef enum logic [2:0] {
      BR_NOP  = 3'b000,
      BR_JMP  = 3'b001,
      BR_BZ   = 3'b010,
      BR_BNZ  = 3'b011,
      BR_BN   = 3'b100,
      BR_CALL = 3'b101,
      BR_RET  = 3'b110,
      BR_RSV  = 3'b111
   } br_op_e;

   localparam int D_DEF = 10;
   localparam int L_DEF = 5;

endpackage

// File: rtl/jump_ctrl_ret_stack.sv
// Return-address stack for CALL/RET.
//   clk, reset : clock and synchronous active-high reset (clears pointer only)
//   push, pop  : push data / pop top on the clock edge
//   data       : return address to push
//   top        : current top of stack (0 when empty)
//   depth      : occupancy, 0..S
//   full/empty : occupancy flags
// A push while full and a pop while empty are silently dropped here; the
// caller records them as overflow/underflow.
module ret_stack #(
   parameter int D = 10,
   parameter int S = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [D-1:0]             data,
   output logic [D-1:0]             top,
   output logic [$clog2(S+1)-1:0]   depth,
   output logic                     full,
   output logic                     empty
);

   localparam int DW = $clog2(S+1);
   localparam int IW = (S > 1) ? $clog2(S) : 1;

   logic [D-1:0]  mem [S];
   logic [DW-1:0] top_ptr;

   assign top_ptr = depth - DW'(1);
   assign full    = (depth == DW'(S));
   assign empty   = (depth == '0);
   assign top     = empty ? '0 : mem[top_ptr[IW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         depth <= '0;
      end else if (push && !full) begin
         depth <= depth + DW'(1);
      end else if (pop && !empty) begin
         depth <= depth - DW'(1);
      end
   end

   // Contents survive reset; only the pointer is cleared.
   always_ff @(posedge clk) begin
      if (!reset && push && !full) begin
         mem[depth[IW-1:0]] <= data;
      end
   end

endmodule

// File: rtl/jump_ctrl.sv
// Initiator side of the program-counter jump interface.
//   clk, reset         : clock, synchronous active-high reset
//   programCounter     : address of the current instruction
//   brOp, lutIdx       : branch opcode and target-LUT index of that instruction
//   flagWe, aluZero/Neg: latch ALU flags on this edge
//   lutWe/Waddr/Wdata  : branch-target LUT write port
//   jumpEn, target     : combinational jump request to the program counter
//   depth              : return-stack occupancy
//   overflow/underflow : sticky CALL-when-full / RET-when-empty
module jump_ctrl
   import jump_ctrl_pkg::*;
#(
   parameter int D = D_DEF,
   parameter int L = L_DEF,
   parameter int S = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [D-1:0]             programCounter,
   input  logic [2:0]               brOp,
   input  logic [L-1:0]             lutIdx,
   input  logic                     flagWe,
   input  logic                     aluZero,
   input  logic                     aluNeg,
   input  logic                     lutWe,
   input  logic [L-1:0]             lutWaddr,
   input  logic [D-1:0]             lutWdata,
   output logic                     jumpEn,
   output logic [D-1:0]             target,
   output logic [$clog2(S+1)-1:0]   depth,
   output logic                     overflow,
   output logic                     underflow
);

   logic [D-1:0] lut [2**L];
   logic         zf, nf;
   br_op_e       op;
   logic         push, pop, full, empty;
   logic [D-1:0] stack_top, ret_addr;

   assign op       = br_op_e'(brOp);
   assign ret_addr = programCounter + D'(1);

   // Decode uses the registered flags and pre-write LUT contents, so a branch
   // sharing a cycle with a flag or LUT write sees the older values.
   always_comb begin
      jumpEn = 1'b0;
      target = '0;
      push   = 1'b0;
      pop    = 1'b0;
      if (!reset) begin
         unique case (op)
            BR_JMP: begin
               jumpEn = 1'b1;
               target = lut[lutIdx];
            end
            BR_BZ: if (zf) begin
               jumpEn = 1'b1;
               target = lut[lutIdx];
            end
            BR_BNZ: if (!zf) begin
               jumpEn = 1'b1;
               target = lut[lutIdx];
            end
            BR_BN: if (nf) begin
               jumpEn = 1'b1;
               target = lut[lutIdx];
            end
            BR_CALL: begin
               jumpEn = 1'b1;
               target = lut[lutIdx];
               push   = 1'b1;
            end
            BR_RET: begin
               pop = 1'b1;
               if (!empty) begin
                  jumpEn = 1'b1;
                  target = stack_top;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         zf        <= 1'b0;
         nf        <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         for (int i = 0; i < 2**L; i++) begin
            lut[i] <= '0;
         end
      end else begin
         if (flagWe) begin
            zf <= aluZero;
            nf <= aluNeg;
         end
         if (lutWe) begin
            lut[lutWaddr] <= lutWdata;
         end
         if (push && full) begin
            overflow <= 1'b1;
         end
         if (pop && empty) begin
            underflow <= 1'b1;
         end
      end
   end

   ret_stack #(.D(D), .S(S)) u_ret_stack (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .data  (ret_addr),
      .top   (stack_top),
      .depth (depth),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed bench for jump_ctrl: a vector table for the single-cycle behaviour
// plus hand-built sequences for stack overflow, wrap and mid-sequence reset.
// Each vector drives inputs after a falling edge, checks outputs 1 ns later
// (depth/overflow/underflow show state before this vector's rising edge),
// then lets the rising edge commit it.
module tb_jump_ctrl;
   import jump_ctrl_pkg::*;

   localparam int D = 10;
   localparam int L = 5;
   localparam int S = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [D-1:0] programCounter;
   logic [2:0]   brOp;
   logic [L-1:0] lutIdx;
   logic         flagWe, aluZero, aluNeg;
   logic         lutWe;
   logic [L-1:0] lutWaddr;
   logic [D-1:0] lutWdata;
   logic         jumpEn;
   logic [D-1:0] target;
   logic [2:0]   depth;
   logic         overflow, underflow;

   always #5 clk = ~clk;

   jump_ctrl #(.D(D), .L(L), .S(S)) dut (
      .clk            (clk),
      .reset          (reset),
      .programCounter (programCounter),
      .brOp           (brOp),
      .lutIdx         (lutIdx),
      .flagWe         (flagWe),
      .aluZero        (aluZero),
      .aluNeg         (aluNeg),
      .lutWe          (lutWe),
      .lutWaddr       (lutWaddr),
      .lutWdata       (lutWdata),
      .jumpEn         (jumpEn),
      .target         (target),
      .depth          (depth),
      .overflow       (overflow),
      .underflow      (underflow)
   );

   typedef struct {
      logic         rst;
      logic [2:0]   op;
      logic [L-1:0] idx;
      logic [D-1:0] pc;
      logic         fwe, z, n;
      logic         lwe;
      logic [L-1:0] lwa;
      logic [D-1:0] lwd;
      logic         ej;
      logic [D-1:0] et;
      logic [2:0]   ed;
      logic         eo, eu;
   } vec_t;

   int tests = 0;
   int fails = 0;
   int step  = 0;
   vec_t tbl[$];

   function automatic vec_t mk(
      input logic rst, input logic [2:0] op, input logic [L-1:0] idx, input logic [D-1:0] pc,
      input logic fwe, input logic z, input logic n,
      input logic lwe, input logic [L-1:0] lwa, input logic [D-1:0] lwd,
      input logic ej, input logic [D-1:0] et, input logic [2:0] ed, input logic eo, input logic eu);
      vec_t v;
      v.rst = rst; v.op = op; v.idx = idx; v.pc = pc;
      v.fwe = fwe; v.z = z; v.n = n;
      v.lwe = lwe; v.lwa = lwa; v.lwd = lwd;
      v.ej = ej; v.et = et; v.ed = ed; v.eo = eo; v.eu = eu;
      return v;
   endfunction

   task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, n, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      reset = v.rst; brOp = v.op; lutIdx = v.idx; programCounter = v.pc;
      flagWe = v.fwe; aluZero = v.z; aluNeg = v.n;
      lutWe = v.lwe; lutWaddr = v.lwa; lutWdata = v.lwd;
      #1;
      chk("jumpEn",    step, 32'(jumpEn),    32'(v.ej));
      chk("target",    step, 32'(target),    32'(v.et));
      chk("depth",     step, 32'(depth),     32'(v.ed));
      chk("overflow",  step, 32'(overflow),  32'(v.eo));
      chk("underflow", step, 32'(underflow), 32'(v.eu));
      step++;
      @(negedge clk);
   endtask

   initial begin
      //             rst op       idx pc      fwe z n  lwe wa wd       ej et      ed o u
      tbl.push_back(mk(1, BR_JMP,  3, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0));
      tbl.push_back(mk(0, BR_NOP,  3, 10'h000, 0, 0, 0, 1, 3, 10'h155, 0, 10'h000, 0, 0, 0));
      tbl.push_back(mk(0, BR_JMP,  3, 10'h000, 0, 0, 0, 0, 0, 10'h000, 1, 10'h155, 0, 0, 0));
      tbl.push_back(mk(0, BR_NOP,  3, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0));
      tbl.push_back(mk(0, BR_BZ,   3, 10'h000, 1, 1, 0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0));
      tbl.push_back(mk(0, BR_BZ,   3, 10'h000, 0, 0, 0, 0, 0, 10'h000, 1, 10'h155, 0, 0, 0));
      tbl.push_back(mk(0, BR_BNZ,  3, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0));
      tbl.push_back(mk(0, BR_BNZ,  3, 10'h000, 1, 0, 1, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0));
      tbl.push_back(mk(0, BR_BN,   3, 10'h000, 0, 0, 0, 0, 0, 10'h000, 1, 10'h155, 0, 0, 0));
      tbl.push_back(mk(0, BR_BNZ,  3, 10'h000, 0, 0, 0, 0, 0, 10'h000, 1, 10'h155, 0, 0, 0));
      tbl.push_back(mk(0, BR_RSV,  3, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0));
      // same-cycle LUT write: read returns the old (reset) value
      tbl.push_back(mk(0, BR_JMP,  1, 10'h000, 0, 0, 0, 1, 1, 10'h040, 1, 10'h000, 0, 0, 0));
      tbl.push_back(mk(0, BR_JMP,  1, 10'h000, 0, 0, 0, 0, 0, 10'h000, 1, 10'h040, 0, 0, 0));
      tbl.push_back(mk(0, BR_CALL, 1, 10'h010, 0, 0, 0, 0, 0, 10'h000, 1, 10'h040, 0, 0, 0));
      tbl.push_back(mk(0, BR_CALL, 1, 10'h041, 0, 0, 0, 0, 0, 10'h000, 1, 10'h040, 1, 0, 0));
      tbl.push_back(mk(0, BR_NOP,  0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 2, 0, 0));
      tbl.push_back(mk(0, BR_RET,  0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 1, 10'h042, 2, 0, 0));
      tbl.push_back(mk(0, BR_RET,  0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 1, 10'h011, 1, 0, 0));
      tbl.push_back(mk(0, BR_RET,  0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0));
      tbl.push_back(mk(0, BR_NOP,  0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 1));
      tbl.push_back(mk(0, BR_JMP,  3, 10'h000, 0, 0, 0, 1, 3, 10'h2AA, 1, 10'h155, 0, 0, 1));
      tbl.push_back(mk(0, BR_JMP,  3, 10'h000, 0, 0, 0, 0, 0, 10'h000, 1, 10'h2AA, 0, 0, 1));

      reset = 1'b1; brOp = BR_NOP; lutIdx = '0; programCounter = '0;
      flagWe = 0; aluZero = 0; aluNeg = 0; lutWe = 0; lutWaddr = '0; lutWdata = '0;
      @(negedge clk);
      @(negedge clk);

      foreach (tbl[i]) apply(tbl[i]);

      // Five CALLs into a 4-deep stack: fifth still jumps but is not pushed.
      for (int i = 0; i < 5; i++) begin
         apply(mk(0, BR_CALL, 3, 10'(10'h100 + i), 0, 0, 0, 0, 0, 10'h000,
                  1, 10'h2AA, 3'((i < 4) ? i : 4), 0, 1));
      end
      apply(mk(0, BR_NOP, 0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 4, 1, 1));
      // Pops come back as pc+1 of the first four calls, newest first.
      for (int i = 0; i < 4; i++) begin
         apply(mk(0, BR_RET, 0, 10'h000, 0, 0, 0, 0, 0, 10'h000,
                  1, 10'(10'h104 - i), 3'(4 - i), 1, 1));
      end

      // Return address wraps at the top of the address space.
      apply(mk(0, BR_CALL, 3, 10'h3FF, 0, 0, 0, 0, 0, 10'h000, 1, 10'h2AA, 0, 1, 1));
      apply(mk(0, BR_RET,  0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 1, 10'h000, 1, 1, 1));

      // Build depth 3, then reset coinciding with CALL, LUT and flag writes.
      for (int i = 0; i < 3; i++) begin
         apply(mk(0, BR_CALL, 3, 10'(10'h200 + i), 0, 0, 0, 0, 0, 10'h000, 1, 10'h2AA, 3'(i), 1, 1));
      end
      apply(mk(1, BR_CALL, 3, 10'h300, 1, 1, 1, 1, 5, 10'h001, 0, 10'h000, 3, 1, 1));
      apply(mk(0, BR_NOP,  0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0));
      apply(mk(0, BR_JMP,  3, 10'h000, 0, 0, 0, 0, 0, 10'h000, 1, 10'h000, 0, 0, 0));
      apply(mk(0, BR_JMP,  5, 10'h000, 0, 0, 0, 0, 0, 10'h000, 1, 10'h000, 0, 0, 0));
      apply(mk(0, BR_BZ,   3, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0));
      apply(mk(0, BR_BN,   3, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0));
      apply(mk(0, BR_RET,  0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0));
      apply(mk(0, BR_NOP,  0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
